// File: rtl/mtsp_alu_wb_collect.sv
// mtsp_alu_wb_collect: buffers ALU results per (source,phase) and round-robin drains each phase to a registered write port
module mtsp_alu_wb_collect #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [2*NUM_SRC-1:0]      src_phase_en_i,
  input  logic [DATA_W*NUM_SRC-1:0] src_data_i,
  input  logic [ADDR_W*NUM_SRC-1:0] src_addr_i,
  output logic [NUM_SRC-1:0]        src_busy_o,
  output logic                      wb0_valid_o,
  input  logic                      wb0_ready_i,
  output logic [ADDR_W-1:0]         wb0_addr_o,
  output logic [DATA_W-1:0]         wb0_data_o,
  output logic                      wb1_valid_o,
  input  logic                      wb1_ready_i,
  output logic [ADDR_W-1:0]         wb1_addr_o,
  output logic [DATA_W-1:0]         wb1_data_o,
  output logic                      ovf_o
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  logic [1:0]              ready, valid, ovf_hit;
  logic [1:0][ADDR_W-1:0]  wb_addr;
  logic [1:0][DATA_W-1:0]  wb_data;
  logic [1:0][NUM_SRC-1:0] slot_v;
  logic                    ovf_q;
  assign ready = {wb1_ready_i, wb0_ready_i};
  for (genvar p = 0; p < 2; p++) begin : g_ph
    logic [NUM_SRC-1:0]             v_q, v_d, en, ld;
    logic [NUM_SRC-1:0][ADDR_W-1:0] a_q;
    logic [NUM_SRC-1:0][DATA_W-1:0] d_q;
    logic [PTR_W-1:0]               ptr_q, gnt;
    logic                           hit, grant, oh, ov_q;
    logic [ADDR_W-1:0]              oa_q;
    logic [DATA_W-1:0]              od_q;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_en
      assign en[i] = src_phase_en_i[2*i+p];
    end
    always_comb begin
      hit = 1'b0;
      gnt = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!hit && v_q[PTR_W'((int'(ptr_q) + k) % NUM_SRC)]) begin
          hit = 1'b1;
          gnt = PTR_W'((int'(ptr_q) + k) % NUM_SRC);
        end
      end
      grant = hit & (!ov_q | ready[p]);
      v_d = v_q;
      ld = '0;
      oh = 1'b0;
      // a slot drained this cycle is free again, so a same-cycle arrival reloads it
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant && gnt == PTR_W'(i)) v_d[i] = 1'b0;
        if (en[i]) begin
          if (v_d[i]) oh = 1'b1;
          else begin
            v_d[i] = 1'b1;
            ld[i] = 1'b1;
          end
        end
      end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q   <= '0;
        a_q   <= '0;
        d_q   <= '0;
        ptr_q <= '0;
        ov_q  <= 1'b0;
        oa_q  <= '0;
        od_q  <= '0;
      end else begin
        v_q <= v_d;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (ld[i]) begin
            a_q[i] <= src_addr_i[i*ADDR_W +: ADDR_W];
            d_q[i] <= src_data_i[i*DATA_W +: DATA_W];
          end
        end
        if (grant) begin
          ptr_q <= PTR_W'((int'(gnt) + 1) % NUM_SRC);
          oa_q  <= a_q[gnt];
          od_q  <= d_q[gnt];
        end
        if (!ov_q || ready[p]) ov_q <= hit;
      end
    end
    assign slot_v[p]  = v_q;
    assign valid[p]   = ov_q;
    assign wb_addr[p] = oa_q;
    assign wb_data[p] = od_q;
    assign ovf_hit[p] = oh;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= 1'b0;
    else ovf_q <= ovf_q | (|ovf_hit);
  end
  assign src_busy_o  = slot_v[0] | slot_v[1];
  assign wb0_valid_o = valid[0];
  assign wb0_addr_o  = wb_addr[0];
  assign wb0_data_o  = wb_data[0];
  assign wb1_valid_o = valid[1];
  assign wb1_addr_o  = wb_addr[1];
  assign wb1_data_o  = wb_data[1];
  assign ovf_o       = ovf_q;
endmodule
